// File: rtl/player_pkg.sv
// Shared encodings for the platformer character controller:
// action state codes, collision flag bit positions and facing constants.
package player_pkg;

    typedef enum logic [1:0] {
        ACT_IDLE = 2'b00,
        ACT_RUN  = 2'b01,
        ACT_JUMP = 2'b10,
        ACT_FALL = 2'b11
    } action_e;

    // Bit positions inside is_collide = {up, down, left, right}
    localparam int COL_UP    = 3;
    localparam int COL_DOWN  = 2;
    localparam int COL_LEFT  = 1;
    localparam int COL_RIGHT = 0;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Grounded action chosen purely from the horizontal buttons
    function automatic action_e ground_action(input logic left, input logic right);
        return (left ^ right) ? ACT_RUN : ACT_IDLE;
    endfunction

endpackage

// File: rtl/player_motion_move_tick.sv
// move_tick: interval counter that pulses tick on the last cycle of each
// interval and restarts from zero. Disabled or cleared -> counter held at 0.
module move_tick #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] interval,
    input  logic             en,
    input  logic             clr,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = en & ~clr & (cnt == interval - 1'b1);

    // Count while enabled, wrap to zero on each tick
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/player_motion.sv
// player_motion: platformer character controller. Turns debounced buttons and
// {up, down, left, right} contact flags into action state, facing direction
// and saturating pixel position, with N-jump, accelerating fall and respawn.
// Optional build macro PLAYER_COYOTE_EN: grace window after walking off an
// edge during which a press still counts as a ground jump.
module player_motion #(
    parameter int POS_W          = 10,
    parameter int INIT_X         = 200,
    parameter int INIT_Y         = 556,
    parameter int X_INV          = 200,
    parameter int JUMP_INV       = 20,
    parameter int APEX_INV       = 110,
    parameter int FALL_START_INV = 110,
    parameter int FALL_MIN_INV   = 40,
    parameter int MAX_JUMPS      = 2,
    parameter int CNT_W          = 8,
    parameter int COYOTE_CYC     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_jump,
    input  logic [3:0]       is_collide,
    input  logic             respawn,
    input  logic [POS_W-1:0] spawn_x,
    input  logic [POS_W-1:0] spawn_y,
    output logic             direction,
    output logic [1:0]       action,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic [2:0]       jumps_used,
    output logic             landed
);

    import player_pkg::*;

    localparam logic [POS_W-1:0] POS_MAX = '1;

    action_e          state;
    logic             jump_q;
    logic [CNT_W-1:0] up_inv;
    logic [CNT_W-1:0] down_inv;

    logic press, one_btn, x_blocked, x_en, air_ok;
    logic up_clr, down_clr;
    logic x_tick, up_tick, down_tick;

`ifdef PLAYER_COYOTE_EN
    localparam int COY_W = $clog2(COYOTE_CYC + 1);
    logic [COY_W-1:0] coyote_cnt;
`endif

    function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v);
        return (v == POS_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [POS_W-1:0] sat_dec(input logic [POS_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    assign press     = btn_jump & ~jump_q;
    assign one_btn   = btn_left ^ btn_right;
    assign x_blocked = btn_left ? is_collide[COL_LEFT] : is_collide[COL_RIGHT];
    assign x_en      = one_btn & ~x_blocked;
    assign air_ok    = press & (jumps_used < 3'(MAX_JUMPS));

    // An accepted air jump restarts the ascent cadence; landing or an air jump
    // out of a fall restarts the descent cadence.
    assign up_clr   = respawn | ((state == ACT_JUMP) & air_ok);
    assign down_clr = respawn | ((state == ACT_FALL) & (air_ok | is_collide[COL_DOWN]));

    move_tick #(.CNT_W(CNT_W)) u_x_tick (
        .clk      (clk),
        .rst      (rst),
        .interval (CNT_W'(X_INV)),
        .en       (x_en),
        .clr      (respawn),
        .tick     (x_tick)
    );

    move_tick #(.CNT_W(CNT_W)) u_up_tick (
        .clk      (clk),
        .rst      (rst),
        .interval (up_inv),
        .en       (state == ACT_JUMP),
        .clr      (up_clr),
        .tick     (up_tick)
    );

    move_tick #(.CNT_W(CNT_W)) u_down_tick (
        .clk      (clk),
        .rst      (rst),
        .interval (down_inv),
        .en       (state == ACT_FALL),
        .clr      (down_clr),
        .tick     (down_tick)
    );

    assign action = state;

    // Action FSM, position, jump bookkeeping and landing pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACT_IDLE;
            direction  <= DIR_RIGHT;
            pos_x      <= POS_W'(INIT_X);
            pos_y      <= POS_W'(INIT_Y);
            jumps_used <= 3'd0;
            landed     <= 1'b0;
            jump_q     <= 1'b0;
            up_inv     <= CNT_W'(JUMP_INV);
            down_inv   <= CNT_W'(FALL_START_INV);
`ifdef PLAYER_COYOTE_EN
            coyote_cnt <= '0;
`endif
        end else begin
            jump_q <= btn_jump;
            landed <= 1'b0;

            if (respawn) begin
                state      <= ACT_FALL;
                pos_x      <= spawn_x;
                pos_y      <= spawn_y;
                jumps_used <= 3'd0;
                up_inv     <= CNT_W'(JUMP_INV);
                down_inv   <= CNT_W'(FALL_START_INV);
`ifdef PLAYER_COYOTE_EN
                coyote_cnt <= '0;
`endif
            end else begin
                if (one_btn) begin
                    direction <= btn_right;
                end
                if (x_tick) begin
                    pos_x <= btn_right ? sat_inc(pos_x) : sat_dec(pos_x);
                end

                case (state)
                    ACT_IDLE, ACT_RUN: begin
                        if (press) begin
                            state      <= ACT_JUMP;
                            jumps_used <= 3'd1;
                            up_inv     <= CNT_W'(JUMP_INV);
                        end else if (!is_collide[COL_DOWN]) begin
                            state    <= ACT_FALL;
                            down_inv <= CNT_W'(FALL_START_INV);
`ifdef PLAYER_COYOTE_EN
                            coyote_cnt <= COY_W'(COYOTE_CYC);
                            jumps_used <= (COYOTE_CYC == 0) ? 3'd1 : 3'd0;
`else
                            jumps_used <= 3'd1;
`endif
                        end else begin
                            state      <= ground_action(btn_left, btn_right);
                            jumps_used <= 3'd0;
                        end
                    end

                    ACT_JUMP: begin
                        if (air_ok) begin
                            jumps_used <= jumps_used + 1'b1;
                            up_inv     <= CNT_W'(JUMP_INV);
                        end else if (is_collide[COL_UP]) begin
                            state    <= ACT_FALL;
                            down_inv <= CNT_W'(FALL_START_INV);
                        end else if (up_tick) begin
                            pos_y  <= sat_dec(pos_y);
                            up_inv <= up_inv + 1'b1;
                            if (up_inv >= CNT_W'(APEX_INV - 1)) begin
                                state    <= ACT_FALL;
                                down_inv <= CNT_W'(FALL_START_INV);
                            end
                        end
                    end

                    ACT_FALL: begin
                        if (is_collide[COL_DOWN]) begin
                            // Landing first; a same-cycle press is then a ground jump
                            landed   <= 1'b1;
                            up_inv   <= CNT_W'(JUMP_INV);
                            down_inv <= CNT_W'(FALL_START_INV);
`ifdef PLAYER_COYOTE_EN
                            coyote_cnt <= '0;
`endif
                            if (press) begin
                                state      <= ACT_JUMP;
                                jumps_used <= 3'd1;
                            end else begin
                                state      <= ground_action(btn_left, btn_right);
                                jumps_used <= 3'd0;
                            end
                        end else if (air_ok) begin
                            state      <= ACT_JUMP;
                            jumps_used <= jumps_used + 1'b1;
                            up_inv     <= CNT_W'(JUMP_INV);
`ifdef PLAYER_COYOTE_EN
                            coyote_cnt <= '0;
`endif
                        end else begin
                            if (down_tick) begin
                                pos_y    <= sat_inc(pos_y);
                                down_inv <= (down_inv > CNT_W'(FALL_MIN_INV)) ?
                                            down_inv - 1'b1 : CNT_W'(FALL_MIN_INV);
                            end
`ifdef PLAYER_COYOTE_EN
                            if (coyote_cnt != '0) begin
                                coyote_cnt <= coyote_cnt - 1'b1;
                                if (coyote_cnt == COY_W'(1)) begin
                                    jumps_used <= 3'd1;
                                end
                            end
`endif
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_motion.sv
// Scoreboard bench for player_motion: directed scenarios plus randomized
// stimulus, checked every cycle against a behavioural model of the rules.
module tb_player_motion;

    localparam int POS_W          = 10;
    localparam int INIT_X         = 200;
    localparam int INIT_Y         = 556;
    localparam int X_INV          = 4;
    localparam int JUMP_INV       = 2;
    localparam int APEX_INV       = 5;
    localparam int FALL_START_INV = 6;
    localparam int FALL_MIN_INV   = 3;
    localparam int MAX_JUMPS      = 2;
    localparam int CNT_W          = 8;
    localparam int COYOTE_CYC     = 16;
    localparam int POS_MAX        = (1 << POS_W) - 1;

    localparam int A_IDLE = 0, A_RUN = 1, A_JUMP = 2, A_FALL = 3;
    localparam logic [3:0] GND = 4'b0100;
    localparam logic [3:0] AIR = 4'b0000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
    logic [3:0]       is_collide = 4'b0;
    logic             respawn = 1'b0;
    logic [POS_W-1:0] spawn_x = '0, spawn_y = '0;
    logic             direction;
    logic [1:0]       action;
    logic [POS_W-1:0] pos_x, pos_y;
    logic [2:0]       jumps_used;
    logic             landed;

    player_motion #(
        .POS_W(POS_W), .INIT_X(INIT_X), .INIT_Y(INIT_Y), .X_INV(X_INV),
        .JUMP_INV(JUMP_INV), .APEX_INV(APEX_INV), .FALL_START_INV(FALL_START_INV),
        .FALL_MIN_INV(FALL_MIN_INV), .MAX_JUMPS(MAX_JUMPS), .CNT_W(CNT_W),
        .COYOTE_CYC(COYOTE_CYC)
    ) dut (
        .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right),
        .btn_jump(btn_jump), .is_collide(is_collide), .respawn(respawn),
        .spawn_x(spawn_x), .spawn_y(spawn_y), .direction(direction),
        .action(action), .pos_x(pos_x), .pos_y(pos_y),
        .jumps_used(jumps_used), .landed(landed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             dir;
        logic [1:0]       act;
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        logic [2:0]       jumps;
        logic             land;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t v;
    } sb_t;

    sb_t   sb_q[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    string phase = "reset";

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    int m_dir, m_act, m_x, m_y, m_jumps, m_landed;
    bit m_prev_jump;
    int x_wait, rise_wait, rise_per, fall_wait, fall_per;

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > POS_MAX) return POS_MAX;
        return v;
    endfunction

    task automatic model_reset();
        m_dir = 1; m_act = A_IDLE; m_x = INIT_X; m_y = INIT_Y;
        m_jumps = 0; m_landed = 0; m_prev_jump = 0;
        x_wait = 0; rise_wait = 0; fall_wait = 0;
        rise_per = JUMP_INV; fall_per = FALL_START_INV;
    endtask

    task automatic start_rise();
        m_act = A_JUMP; rise_per = JUMP_INV; rise_wait = 0;
    endtask

    task automatic start_fall();
        m_act = A_FALL; fall_per = FALL_START_INV; fall_wait = 0;
    endtask

    // One clock of the character rules applied to the current inputs
    task automatic model_step();
        bit press, one, blocked;
        press = btn_jump && !m_prev_jump;
        m_prev_jump = btn_jump;
        m_landed = 0;
        if (respawn) begin
            m_x = spawn_x; m_y = spawn_y; m_jumps = 0;
            x_wait = 0; rise_wait = 0; rise_per = JUMP_INV;
            start_fall();
            return;
        end
        one = (btn_left != btn_right);
        if (one) m_dir = btn_right;
        blocked = btn_left ? is_collide[1] : is_collide[0];
        if (one && !blocked) begin
            x_wait++;
            if (x_wait == X_INV) begin
                x_wait = 0;
                m_x = clamp(m_x + (btn_right ? 1 : -1));
            end
        end else begin
            x_wait = 0;
        end
        case (m_act)
            A_IDLE, A_RUN: begin
                if (press) begin
                    start_rise(); m_jumps = 1;
                end else if (!is_collide[2]) begin
                    start_fall(); m_jumps = 1;
                end else begin
                    m_act = one ? A_RUN : A_IDLE; m_jumps = 0;
                end
            end
            A_JUMP: begin
                if (press && m_jumps < MAX_JUMPS) begin
                    start_rise(); m_jumps++;
                end else if (is_collide[3]) begin
                    start_fall();
                end else begin
                    rise_wait++;
                    if (rise_wait == rise_per) begin
                        rise_wait = 0;
                        m_y = clamp(m_y - 1);
                        rise_per++;
                        if (rise_per == APEX_INV) start_fall();
                    end
                end
            end
            default: begin
                if (is_collide[2]) begin
                    m_landed = 1; fall_wait = 0;
                    if (press) begin
                        start_rise(); m_jumps = 1;
                    end else begin
                        m_act = one ? A_RUN : A_IDLE; m_jumps = 0;
                    end
                end else if (press && m_jumps < MAX_JUMPS) begin
                    start_rise(); m_jumps++;
                end else begin
                    fall_wait++;
                    if (fall_wait == fall_per) begin
                        fall_wait = 0;
                        m_y = clamp(m_y + 1);
                        fall_per = (fall_per - 1 < FALL_MIN_INV) ? FALL_MIN_INV : fall_per - 1;
                    end
                end
            end
        endcase
    endtask

    task automatic push_exp(input int at);
        sb_t e;
        e.cyc     = at;
        e.v.dir   = 1'(m_dir);
        e.v.act   = 2'(m_act);
        e.v.x     = POS_W'(m_x);
        e.v.y     = POS_W'(m_y);
        e.v.jumps = 3'(m_jumps);
        e.v.land  = 1'(m_landed);
        sb_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    task automatic check(input string name, input int at, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d: got dir=%0d act=%0d x=%0d y=%0d jumps=%0d landed=%0d, expected dir=%0d act=%0d x=%0d y=%0d jumps=%0d landed=%0d",
                     name, at, got.dir, got.act, got.x, got.y, got.jumps, got.land,
                     exp.dir, exp.act, exp.x, exp.y, exp.jumps, exp.land);
        end
    endtask

    sb_t  mon_e;
    obs_t mon_got;

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e   = sb_q.pop_front();
            mon_got = {direction, action, pos_x, pos_y, jumps_used, landed};
            check(phase, mon_e.cyc, mon_got, mon_e.v);
        end
    end

    // ---------------- driver ----------------
    task automatic set_in(input bit l, input bit r, input bit j, input logic [3:0] col);
        btn_left = l; btn_right = r; btn_jump = j; is_collide = col;
    endtask

    task automatic cycle();
        model_step();
        push_exp(cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic respawn_at(input int sx, input int sy);
        respawn = 1'b1; spawn_x = POS_W'(sx); spawn_y = POS_W'(sy);
        cycle();
        respawn = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        set_in(0, 0, 0, AIR);
        respawn = 1'b0;
        model_reset();
        push_exp(cyc);
        @(posedge clk);
        #1;
        push_exp(cyc);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        do_reset();

        phase = "run_right";
        set_in(0, 1, 0, GND); run(12);
        set_in(0, 0, 0, GND); run(3);
        set_in(0, 1, 0, GND); run(3);
        set_in(0, 0, 0, GND); run(1);
        set_in(0, 1, 0, GND); run(4);
        set_in(1, 1, 0, GND); run(5);
        set_in(1, 0, 0, GND); run(9);
        set_in(0, 0, 0, GND); run(2);

        phase = "jump_fall_land";
        set_in(0, 0, 1, GND); run(1);
        set_in(0, 0, 0, AIR); run(40);
        set_in(0, 0, 0, GND); run(3);

        phase = "multi_jump";
        set_in(0, 0, 1, GND); run(1);
        set_in(0, 0, 0, AIR); run(2);
        set_in(0, 0, 1, AIR); run(1);
        set_in(0, 0, 0, AIR); run(2);
        set_in(0, 0, 1, AIR); run(1);
        set_in(0, 0, 0, AIR); run(20);
        set_in(0, 0, 0, GND); run(2);

        phase = "held_jump";
        set_in(0, 0, 1, GND); run(1);
        set_in(0, 0, 1, AIR); run(30);
        set_in(0, 0, 1, GND); run(2);
        set_in(0, 0, 0, GND); run(2);

        phase = "land_and_press";
        set_in(0, 0, 1, GND); run(1);
        set_in(0, 0, 0, AIR); run(12);
        set_in(0, 0, 1, GND); run(1);
        set_in(0, 0, 0, AIR); run(3);
        set_in(0, 0, 0, GND); run(2);

        phase = "walk_off";
        set_in(0, 1, 0, AIR); run(6);
        set_in(0, 0, 0, GND); run(2);

        phase = "sat_x_low";
        respawn_at(1, 60);
        set_in(1, 0, 0, AIR); run(12);
        set_in(1, 0, 0, 4'b0110); run(8);

        phase = "sat_x_high";
        respawn_at(1022, 60);
        set_in(0, 1, 0, AIR); run(12);
        set_in(0, 1, 0, 4'b0101); run(6);

        phase = "up_bump";
        set_in(0, 0, 1, GND); run(1);
        set_in(0, 0, 0, AIR); run(1);
        set_in(0, 0, 0, 4'b1000); run(3);
        set_in(0, 0, 0, GND); run(2);

        phase = "respawn_mid_jump";
        set_in(0, 0, 1, GND); run(1);
        set_in(0, 0, 0, AIR); run(4);
        respawn_at(50, 60);
        run(5);

        phase = "reset_mid_fall";
        run(3);
        do_reset();
        set_in(0, 0, 0, GND); run(3);

        phase = "sat_y";
        respawn_at(100, 1);
        set_in(0, 0, 0, GND); run(2);
        set_in(0, 0, 1, GND); run(1);
        set_in(0, 0, 0, AIR); run(10);
        respawn_at(100, 1022);
        run(15);

        phase = "random";
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) btn_left  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) btn_right = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) btn_jump  = ~btn_jump;
            if ($urandom_range(0, 14) == 0) is_collide[2] = ~is_collide[2];
            if ($urandom_range(0, 19) == 0) is_collide[3] = ~is_collide[3];
            if ($urandom_range(0, 19) == 0) is_collide[1] = ~is_collide[1];
            if ($urandom_range(0, 19) == 0) is_collide[0] = ~is_collide[0];
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 299) == 0) begin
                respawn_at(int'($urandom_range(0, POS_MAX)), int'($urandom_range(0, POS_MAX)));
            end else begin
                cycle();
            end
        end

        phase = "drain";
        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
